// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: register-id
//   width, FSM state encodings and the load-use compare helper.
//   No ports (package).
package pipe_hazard_ctrl_pkg;

  localparam int RegIdWidth = 5;

  // State encodings are kept as plain constants so legacy code that
  // compares raw state bits keeps working.
  localparam logic [1:0] PHC_RUN      = 2'd0;
  localparam logic [1:0] PHC_MEM_WAIT = 2'd1;
  localparam logic [1:0] PHC_REDIRECT = 2'd2;

  // True when the ID instruction reads a register that the load in EX is
  // about to write. x0 is never a real dependency.
  function automatic logic load_use_hit(
    input logic [RegIdWidth-1:0] rs1,
    input logic [RegIdWidth-1:0] rs2,
    input logic                  rs1_used,
    input logic                  rs2_used,
    input logic [RegIdWidth-1:0] rd,
    input logic                  wen,
    input logic                  is_load
  );
    return is_load && wen && (rd != '0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// phc_perf_cnt
//   32-bit saturating event counter, cleared by synchronous reset.
//   Ports: clk, rst (sync, active-high), inc (count this cycle),
//          count (current value).
module phc_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. Inserts a single bubble
//   on load-use hazards, freezes every stage while MEM waits on memory
//   (aborting with mem_err after MEM_TIMEOUT wait cycles) and squashes
//   wrong-path instructions for REDIRECT_BUBBLES cycles after a redirect.
//   Inputs : clk, rst (sync, active-high), ID source regs/uses, EX dest/
//            wen/is_load/redirect, MEM request/ack.
//   Outputs: pc/if_id/id_ex/ex_mem/mem_wb write enables, if_id_flush,
//            id_ex_flush, mem_err (one-cycle timeout pulse).
//   Optional: define STALL_PERF_EN to add the saturating 32-bit counters
//            perf_loaduse_cnt, perf_memwait_cnt and perf_redirect_cnt.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 2,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegIdWidth-1:0] rs1_ID,
  input  logic [RegIdWidth-1:0] rs2_ID,
  input  logic                  rs1_used_ID,
  input  logic                  rs2_used_ID,
  input  logic [RegIdWidth-1:0] rd_EX,
  input  logic                  wen_EX,
  input  logic                  is_load_EX,
  input  logic                  redirect_EX,
  input  logic                  mem_req_MEM,
  input  logic                  mem_ack_MEM,
  output logic                  pc_wen,
  output logic                  if_id_wen,
  output logic                  if_id_flush,
  output logic                  id_ex_wen,
  output logic                  id_ex_flush,
  output logic                  ex_mem_wen,
  output logic                  mem_wb_wen,
  output logic                  mem_err
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]           perf_loaduse_cnt,
  output logic [31:0]           perf_memwait_cnt,
  output logic [31:0]           perf_redirect_cnt
`endif
);

  localparam int WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam int BubW  = $clog2(REDIRECT_BUBBLES + 1);
  localparam logic [WaitW-1:0] WaitMax   = WaitW'(MEM_TIMEOUT);
  localparam logic [BubW-1:0]  BubReload = BubW'(REDIRECT_BUBBLES - 1);

  logic [1:0]       state_q, state_d;
  logic             ret_redirect_q, ret_redirect_d;  // resume REDIRECT after MEM_WAIT
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [BubW-1:0]  bub_cnt_q, bub_cnt_d;

  logic mem_stall;
  logic load_use;
  logic loaduse_inc, memwait_inc, redirect_inc;

  assign mem_stall = mem_req_MEM && !mem_ack_MEM;
  assign load_use  = load_use_hit(rs1_ID, rs2_ID, rs1_used_ID, rs2_used_ID,
                                  rd_EX, wen_EX, is_load_EX);

  always_comb begin
    state_d        = state_q;
    ret_redirect_d = ret_redirect_q;
    wait_cnt_d     = wait_cnt_q;
    bub_cnt_d      = bub_cnt_q;
    pc_wen         = 1'b1;
    if_id_wen      = 1'b1;
    id_ex_wen      = 1'b1;
    ex_mem_wen     = 1'b1;
    mem_wb_wen     = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    mem_err        = 1'b0;
    loaduse_inc    = 1'b0;
    memwait_inc    = 1'b0;
    redirect_inc   = 1'b0;

    if (rst) begin
      pc_wen         = 1'b0;
      if_id_wen      = 1'b0;
      id_ex_wen      = 1'b0;
      ex_mem_wen     = 1'b0;
      mem_wb_wen     = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      state_d        = PHC_RUN;
      ret_redirect_d = 1'b0;
      wait_cnt_d     = '0;
      bub_cnt_d      = '0;
    end else begin
      case (state_q)
        PHC_MEM_WAIT: begin
          if (mem_ack_MEM) begin
            // Pipe advances on the ack cycle. If a redirect was frozen,
            // keep squashing IF_ID so no wrong-path fetch slips into ID;
            // the remaining bubble count resumes next cycle.
            state_d     = ret_redirect_q ? PHC_REDIRECT : PHC_RUN;
            if_id_flush = ret_redirect_q;
            wait_cnt_d  = '0;
          end else if (wait_cnt_q == WaitMax) begin
            // Abort: release the pipe, the core discards the MEM result.
            mem_err        = 1'b1;
            state_d        = PHC_RUN;
            ret_redirect_d = 1'b0;
            wait_cnt_d     = '0;
            bub_cnt_d      = '0;
          end else begin
            pc_wen      = 1'b0;
            if_id_wen   = 1'b0;
            id_ex_wen   = 1'b0;
            ex_mem_wen  = 1'b0;
            mem_wb_wen  = 1'b0;
            wait_cnt_d  = wait_cnt_q + 1'b1;
            memwait_inc = 1'b1;
          end
        end

        default: begin
          // RUN and REDIRECT; any unused encoding falls back to RUN.
          state_d = (state_q == PHC_REDIRECT) ? PHC_REDIRECT : PHC_RUN;
          if (mem_stall) begin
            pc_wen         = 1'b0;
            if_id_wen      = 1'b0;
            id_ex_wen      = 1'b0;
            ex_mem_wen     = 1'b0;
            mem_wb_wen     = 1'b0;
            state_d        = PHC_MEM_WAIT;
            ret_redirect_d = (state_q == PHC_REDIRECT);
            wait_cnt_d     = '0;
            memwait_inc    = 1'b1;
          end else if (redirect_EX) begin
            // New redirect (or restart while already redirecting).
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            redirect_inc = 1'b1;
            if (REDIRECT_BUBBLES > 1) begin
              state_d   = PHC_REDIRECT;
              bub_cnt_d = BubReload;
            end else begin
              state_d   = PHC_RUN;
              bub_cnt_d = '0;
            end
          end else if (state_q == PHC_REDIRECT) begin
            // ID holds a bubble here, so load-use cannot apply.
            if_id_flush  = 1'b1;
            redirect_inc = 1'b1;
            if (bub_cnt_q <= BubW'(1)) begin
              state_d   = PHC_RUN;
              bub_cnt_d = '0;
            end else begin
              bub_cnt_d = bub_cnt_q - 1'b1;
            end
          end else if (load_use) begin
            pc_wen      = 1'b0;
            if_id_wen   = 1'b0;
            id_ex_flush = 1'b1;
            loaduse_inc = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= PHC_RUN;
      ret_redirect_q <= 1'b0;
      wait_cnt_q     <= '0;
      bub_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      ret_redirect_q <= ret_redirect_d;
      wait_cnt_q     <= wait_cnt_d;
      bub_cnt_q      <= bub_cnt_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [2:0]  perf_inc;
  logic [31:0] perf_cnt [3];

  assign perf_inc = {redirect_inc, memwait_inc, loaduse_inc};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    phc_perf_cnt u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (perf_inc[gi]),
      .count (perf_cnt[gi])
    );
  end

  assign perf_loaduse_cnt  = perf_cnt[0];
  assign perf_memwait_cnt  = perf_cnt[1];
  assign perf_redirect_cnt = perf_cnt[2];
`else
  logic unused_perf;
  assign unused_perf = ^{loaduse_inc, memwait_inc, redirect_inc};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed table of per-cycle vectors for pipe_hazard_ctrl
//   (REDIRECT_BUBBLES=2, MEM_TIMEOUT=4), followed by hand-written
//   multi-cycle sequences for timeout and reset-during-wait.
//   Expected output vector order: {pc, if_id_wen, if_id_flush, id_ex_wen,
//   id_ex_flush, ex_mem_wen, mem_wb_wen, mem_err}.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] E_RST   = 8'b0010_1000;
  localparam logic [7:0] E_IDLE  = 8'b1101_0110;
  localparam logic [7:0] E_LU    = 8'b0001_1110;
  localparam logic [7:0] E_RDR1  = 8'b1111_1110;
  localparam logic [7:0] E_RDR2  = 8'b1111_0110;
  localparam logic [7:0] E_STALL = 8'b0000_0000;
  localparam logic [7:0] E_ERR   = 8'b1101_0111;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic [4:0] rd;
    logic       wen;
    logic       ld;
    logic       redir;
    logic       req;
    logic       ack;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
  logic       rs1_used_ID = 1'b0, rs2_used_ID = 1'b0;
  logic       wen_EX = 1'b0, is_load_EX = 1'b0, redirect_EX = 1'b0;
  logic       mem_req_MEM = 1'b0, mem_ack_MEM = 1'b0;
  logic       pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush;
  logic       ex_mem_wen, mem_wb_wen, mem_err;
`ifdef STALL_PERF_EN
  logic [31:0] perf_loaduse_cnt, perf_memwait_cnt, perf_redirect_cnt;
`endif

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REDIRECT_BUBBLES (2),
    .MEM_TIMEOUT      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .rs1_used_ID (rs1_used_ID),
    .rs2_used_ID (rs2_used_ID),
    .rd_EX       (rd_EX),
    .wen_EX      (wen_EX),
    .is_load_EX  (is_load_EX),
    .redirect_EX (redirect_EX),
    .mem_req_MEM (mem_req_MEM),
    .mem_ack_MEM (mem_ack_MEM),
    .pc_wen      (pc_wen),
    .if_id_wen   (if_id_wen),
    .if_id_flush (if_id_flush),
    .id_ex_wen   (id_ex_wen),
    .id_ex_flush (id_ex_flush),
    .ex_mem_wen  (ex_mem_wen),
    .mem_wb_wen  (mem_wb_wen),
    .mem_err     (mem_err)
`ifdef STALL_PERF_EN
    ,
    .perf_loaduse_cnt  (perf_loaduse_cnt),
    .perf_memwait_cnt  (perf_memwait_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  function automatic vec_t mk(input string n, input logic r,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic u1, input logic u2,
                              input logic [4:0] d, input logic w,
                              input logic l, input logic rd_, input logic rq,
                              input logic ak, input logic [7:0] e);
    vec_t v;
    v.name = n; v.rst = r; v.rs1 = s1; v.rs2 = s2; v.rs1u = u1; v.rs2u = u2;
    v.rd = d; v.wen = w; v.ld = l; v.redir = rd_; v.req = rq; v.ack = ak;
    v.exp = e;
    return v;
  endfunction

  // Plain cycle: no hazard, only control inputs.
  function automatic vec_t ctl(input string n, input logic r, input logic rd_,
                               input logic rq, input logic ak,
                               input logic [7:0] e);
    return mk(n, r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, rd_, rq, ak, e);
  endfunction

  // Drive one cycle's inputs after the falling edge, check the
  // combinational outputs before the next rising edge.
  task automatic apply(input vec_t v);
    logic [7:0] act;
    @(negedge clk);
    rst = v.rst; rs1_ID = v.rs1; rs2_ID = v.rs2;
    rs1_used_ID = v.rs1u; rs2_used_ID = v.rs2u; rd_EX = v.rd;
    wen_EX = v.wen; is_load_EX = v.ld; redirect_EX = v.redir;
    mem_req_MEM = v.req; mem_ack_MEM = v.ack;
    #1;
    act = {pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush,
           ex_mem_wen, mem_wb_wen, mem_err};
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", v.name, act, v.exp);
    end else begin
      $display("ok   %s: %b", v.name, act);
    end
  endtask

  initial begin
    // Directed per-cycle table; state carries across rows.
    tbl.push_back(ctl("reset0", 1, 0, 0, 0, E_RST));
    tbl.push_back(ctl("reset1", 1, 0, 0, 0, E_RST));
    tbl.push_back(ctl("idle", 0, 0, 0, 0, E_IDLE));
    tbl.push_back(mk("lu_rs2_x5", 0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0, 0, E_LU));
    tbl.push_back(ctl("after_lu", 0, 0, 0, 0, E_IDLE));
    tbl.push_back(mk("ld_x0_rs1_x0", 0, 5'd0, 5'd4, 1, 0, 5'd0, 1, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk("lu_rs1_unused", 0, 5'd7, 5'd3, 0, 1, 5'd7, 1, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk("lu_rs1_x9", 0, 5'd9, 5'd2, 1, 1, 5'd9, 1, 1, 0, 0, 0, E_LU));
    tbl.push_back(mk("ld_no_wen", 0, 5'd9, 5'd2, 1, 1, 5'd9, 0, 1, 0, 0, 0, E_IDLE));
    tbl.push_back(mk("alu_dep", 0, 5'd9, 5'd2, 1, 1, 5'd9, 1, 0, 0, 0, 0, E_IDLE));
    tbl.push_back(ctl("redir_c1", 0, 1, 0, 0, E_RDR1));
    tbl.push_back(ctl("redir_c2", 0, 0, 0, 0, E_RDR2));
    tbl.push_back(ctl("redir_done", 0, 0, 0, 0, E_IDLE));
    tbl.push_back(mk("redir_over_lu", 0, 5'd6, 5'd0, 1, 0, 5'd6, 1, 1, 1, 0, 0, E_RDR1));
    tbl.push_back(mk("redirect_ign_lu", 0, 5'd6, 5'd0, 1, 0, 5'd6, 1, 1, 0, 0, 0, E_RDR2));
    tbl.push_back(ctl("idle2", 0, 0, 0, 0, E_IDLE));
    tbl.push_back(ctl("mem_w1", 0, 0, 1, 0, E_STALL));
    tbl.push_back(ctl("mem_w2", 0, 0, 1, 0, E_STALL));
    tbl.push_back(ctl("mem_w3", 0, 0, 1, 0, E_STALL));
    tbl.push_back(ctl("mem_ack", 0, 0, 1, 1, E_IDLE));
    tbl.push_back(ctl("post_ack_run", 0, 0, 0, 0, E_IDLE));
    tbl.push_back(ctl("req_ack_same", 0, 0, 1, 1, E_IDLE));
    tbl.push_back(ctl("stall_over_redir", 0, 1, 1, 0, E_STALL));
    tbl.push_back(ctl("ack_ret_run", 0, 1, 1, 1, E_IDLE));
    tbl.push_back(ctl("redir_again", 0, 1, 0, 0, E_RDR1));
    tbl.push_back(ctl("stall_in_redir", 0, 0, 1, 0, E_STALL));
    tbl.push_back(ctl("stall_in_redir2", 0, 0, 1, 0, E_STALL));
    tbl.push_back(ctl("ack_ret_redir", 0, 0, 1, 1, E_RDR2));
    tbl.push_back(ctl("redir_resume", 0, 0, 0, 0, E_RDR2));
    tbl.push_back(ctl("redir_end", 0, 0, 0, 0, E_IDLE));
    tbl.push_back(ctl("restart_a", 0, 1, 0, 0, E_RDR1));
    tbl.push_back(ctl("restart_b", 0, 1, 0, 0, E_RDR1));
    tbl.push_back(ctl("restart_tail", 0, 0, 0, 0, E_RDR2));
    tbl.push_back(ctl("restart_done", 0, 0, 0, 0, E_IDLE));

    foreach (tbl[i]) apply(tbl[i]);

    // Timeout: entry stall, four counted waits, abort on the fifth.
    apply(ctl("to_entry", 0, 0, 1, 0, E_STALL));
    for (int k = 0; k < 4; k++) apply(ctl("to_wait", 0, 0, 1, 0, E_STALL));
    apply(ctl("to_abort", 0, 0, 1, 0, E_ERR));
    apply(ctl("to_after", 0, 0, 0, 0, E_IDLE));

    // Ack arriving exactly at the timeout count wins over the abort.
    apply(ctl("late_entry", 0, 0, 1, 0, E_STALL));
    for (int k = 0; k < 4; k++) apply(ctl("late_wait", 0, 0, 1, 0, E_STALL));
    apply(ctl("late_ack", 0, 0, 1, 1, E_IDLE));

    // Reset while waiting with a redirect frozen.
    apply(ctl("rw_redir", 0, 1, 0, 0, E_RDR1));
    apply(ctl("rw_stall", 0, 0, 1, 0, E_STALL));
    apply(ctl("rw_stall2", 0, 0, 1, 0, E_STALL));
    apply(ctl("rw_reset", 1, 0, 1, 0, E_RST));
    apply(ctl("rw_idle", 0, 0, 0, 0, E_IDLE));
    apply(ctl("rw_idle2", 0, 0, 0, 0, E_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
